// File: rtl/exu_mdu.sv
// Iterative RV32/64 M-extension multiply/divide unit: one result bit per cycle,
// with valid/ready handshakes on the request and result sides.
module exu_mdu #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            mdu_i_flush,
    input  logic            mdu_i_valid,
    output logic            mdu_o_ready,
    input  logic [2:0]      mdu_i_op,
    input  logic [XLEN-1:0] mdu_i_a,
    input  logic [XLEN-1:0] mdu_i_b,
    output logic            mdu_o_valid,
    input  logic            mdu_i_ready,
    output logic [XLEN-1:0] mdu_o_data
);
    localparam int CNT_W = $clog2(XLEN) + 1;

    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_REM    = 3'b110;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [2:0]        op_reg, op_next;
    logic [XLEN-1:0]   acc_reg, acc_next;    // product high half / partial remainder
    logic [XLEN-1:0]   lo_reg, lo_next;      // multiplier -> product low half / dividend -> quotient
    logic [XLEN-1:0]   b_reg, b_next;        // multiplicand / divisor magnitude
    logic              neg_reg, neg_next;
    logic [XLEN-1:0]   data_reg, data_next;

    // Operand decode at accept time
    logic            a_signed, b_signed, a_neg, b_neg, neg_in;
    logic [XLEN-1:0] a_mag, b_mag, fast_res;
    logic            div_zero, div_ovf;

    assign a_signed = (mdu_i_op == OP_MULH) || (mdu_i_op == OP_MULHSU) ||
                      (mdu_i_op == OP_DIV)  || (mdu_i_op == OP_REM);
    assign b_signed = (mdu_i_op == OP_MULH) || (mdu_i_op == OP_DIV) || (mdu_i_op == OP_REM);
    assign a_neg    = a_signed && mdu_i_a[XLEN-1];
    assign b_neg    = b_signed && mdu_i_b[XLEN-1];
    assign a_mag    = a_neg ? -mdu_i_a : mdu_i_a;
    assign b_mag    = b_neg ? -mdu_i_b : mdu_i_b;
    // Remainder follows the dividend sign; everything else follows the product sign
    assign neg_in   = (mdu_i_op[2] && mdu_i_op[1]) ? a_neg : (a_neg ^ b_neg);

    assign div_zero = mdu_i_op[2] && (mdu_i_b == '0);
    assign div_ovf  = ((mdu_i_op == OP_DIV) || (mdu_i_op == OP_REM)) &&
                      (mdu_i_a == {1'b1, {(XLEN-1){1'b0}}}) && (mdu_i_b == '1);
    assign fast_res = mdu_i_op[1] ? (div_zero ? mdu_i_a : '0)
                                  : (div_zero ? '1 : mdu_i_a);

    // One iteration of each datapath
    logic [XLEN:0]   mul_sum, rem_shift, div_diff;

    assign mul_sum   = {1'b0, acc_reg} + {1'b0, (lo_reg[0] ? b_reg : '0)};
    assign rem_shift = {acc_reg, lo_reg[XLEN-1]};
    assign div_diff  = rem_shift - {1'b0, b_reg};

    // Sign correction and result selection
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   quot_s, rem_s, final_res;

    assign prod_s = neg_reg ? -{acc_reg, lo_reg} : {acc_reg, lo_reg};
    assign quot_s = neg_reg ? -lo_reg : lo_reg;
    assign rem_s  = neg_reg ? -acc_reg : acc_reg;

    always_comb begin
        final_res = prod_s[2*XLEN-1:XLEN];
        if (op_reg[2])
            final_res = op_reg[1] ? rem_s : quot_s;
        else if (op_reg[1:0] == 2'b00)
            final_res = prod_s[XLEN-1:0];
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        op_next    = op_reg;
        acc_next   = acc_reg;
        lo_next    = lo_reg;
        b_next     = b_reg;
        neg_next   = neg_reg;
        data_next  = data_reg;
        if (mdu_i_flush) begin
            state_next = S_IDLE;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (mdu_i_valid) begin
                        op_next  = mdu_i_op;
                        acc_next = '0;
                        lo_next  = a_mag;
                        b_next   = b_mag;
                        neg_next = neg_in;
                        cnt_next = CNT_W'(XLEN);
                        if (div_zero || div_ovf) begin
                            data_next  = fast_res;
                            state_next = S_DONE;
                        end else begin
                            state_next = S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    if (cnt_reg == '0) begin
                        data_next  = final_res;
                        state_next = S_DONE;
                    end else begin
                        cnt_next = cnt_reg - CNT_W'(1);
                        if (op_reg[2]) begin
                            if (!div_diff[XLEN]) begin
                                acc_next = div_diff[XLEN-1:0];
                                lo_next  = {lo_reg[XLEN-2:0], 1'b1};
                            end else begin
                                acc_next = rem_shift[XLEN-1:0];
                                lo_next  = {lo_reg[XLEN-2:0], 1'b0};
                            end
                        end else begin
                            acc_next = mul_sum[XLEN:1];
                            lo_next  = {mul_sum[0], lo_reg[XLEN-1:1]};
                        end
                    end
                end
                S_DONE: begin
                    if (mdu_i_ready)
                        state_next = S_IDLE;
                end
                default: state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_IDLE;
            cnt_reg   <= '0;
            op_reg    <= '0;
            acc_reg   <= '0;
            lo_reg    <= '0;
            b_reg     <= '0;
            neg_reg   <= 1'b0;
            data_reg  <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            op_reg    <= op_next;
            acc_reg   <= acc_next;
            lo_reg    <= lo_next;
            b_reg     <= b_next;
            neg_reg   <= neg_next;
            data_reg  <= data_next;
        end
    end

    assign mdu_o_ready = (state_reg == S_IDLE);
    assign mdu_o_valid = (state_reg == S_DONE);
    assign mdu_o_data  = data_reg;

endmodule
